// File: rtl/rx_word_fanout_if.sv
// Byte-stream input side and per-channel word output side of rx_word_fanout.
interface rx_word_fanout_if #(
    parameter int unsigned pDATA_WIDTH     = 8,
    parameter int unsigned pBYTES_PER_WORD = 4,
    parameter int unsigned pN_OUT          = 3
);
    localparam int unsigned EMPTY_W = $clog2(pBYTES_PER_WORD);
    localparam int unsigned WORD_W  = pBYTES_PER_WORD * pDATA_WIDTH;

    logic                          i_rx_dv;
    logic                          i_rx_er;
    logic [pDATA_WIDTH-1:0]        i_rx_d;
    logic                          i_dst_valid;
    logic [pN_OUT-1:0]             i_dst_mask;
    logic [pN_OUT*WORD_W-1:0]      o_word;
    logic [pN_OUT-1:0]             o_valid;
    logic [pN_OUT-1:0]             o_sof;
    logic [pN_OUT-1:0]             o_eof;
    logic [pN_OUT*EMPTY_W-1:0]     o_empty;
    logic [pN_OUT-1:0]             o_drop;
    logic                          o_busy;

    modport master (
        output i_rx_dv, i_rx_er, i_rx_d, i_dst_valid, i_dst_mask,
        input  o_word, o_valid, o_sof, o_eof, o_empty, o_drop, o_busy
    );

    modport slave (
        input  i_rx_dv, i_rx_er, i_rx_d, i_dst_valid, i_dst_mask,
        output o_word, o_valid, o_sof, o_eof, o_empty, o_drop, o_busy
    );
endinterface

// File: rtl/rx_word_fanout.sv
// Packs the RX byte stream into words and fans each frame out to pN_OUT channels,
// with a one-word hold register so the last word can carry eof/empty.
module rx_word_fanout #(
    parameter int unsigned pDATA_WIDTH     = 8,
    parameter int unsigned pBYTES_PER_WORD = 4,
    parameter int unsigned pN_OUT          = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    rx_word_fanout_if.slave  bus
);
    localparam int unsigned DW  = pDATA_WIDTH;
    localparam int unsigned BPW = pBYTES_PER_WORD;
    localparam int unsigned NO  = pN_OUT;
    localparam int unsigned CW  = $clog2(pBYTES_PER_WORD);
    localparam int unsigned WW  = BPW * DW;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PACK    = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WW-1:0] part_q, part_d;
    logic [WW-1:0] hold_q, hold_d;
    logic          hold_full_q, hold_full_d;
    logic [NO-1:0] en_q, en_d;
    logic          mask_taken_q, mask_taken_d;
    logic          first_done_q, first_done_d;
    logic [WW-1:0] word_q, word_d;
    logic [NO-1:0] valid_q, valid_d;
    logic [NO-1:0] sof_q, sof_d;
    logic [NO-1:0] eof_q, eof_d;
    logic [CW-1:0] empty_q, empty_d;
    logic [NO-1:0] drop_q, drop_d;
    logic          busy_q, busy_d;

    logic          out_go;
    logic          out_last;
    logic [CW-1:0] ins_idx;
    logic [WW-1:0] ins_base;
    logic [WW-1:0] part_ins;

    // State register and registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            part_q       <= '0;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            en_q         <= '1;
            mask_taken_q <= 1'b0;
            first_done_q <= 1'b0;
            word_q       <= '0;
            valid_q      <= '0;
            sof_q        <= '0;
            eof_q        <= '0;
            empty_q      <= '0;
            drop_q       <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            part_q       <= part_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            en_q         <= en_d;
            mask_taken_q <= mask_taken_d;
            first_done_q <= first_done_d;
            word_q       <= word_d;
            valid_q      <= valid_d;
            sof_q        <= sof_d;
            eof_q        <= eof_d;
            empty_q      <= empty_d;
            drop_q       <= drop_d;
            busy_q       <= busy_d;
        end
    end

    // Next state, packing, mask handling and output decode
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        part_d       = part_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        en_d         = en_q;
        mask_taken_d = mask_taken_q;
        first_done_d = first_done_q;
        word_d       = word_q;
        valid_d      = '0;
        sof_d        = '0;
        eof_d        = '0;
        empty_d      = '0;
        drop_d       = '0;
        out_go       = 1'b0;
        out_last     = 1'b0;

        // Incoming byte lands MSB-first at the current byte slot
        ins_idx  = (state_q == ST_IDLE) ? '0 : cnt_q;
        ins_base = (state_q == ST_IDLE) ? '0 : part_q;
        part_ins = ins_base;
        for (int i = 0; i < int'(BPW); i++) begin
            if (ins_idx == CW'(i)) part_ins[(int'(BPW) - 1 - i) * int'(DW) +: DW] = bus.i_rx_d;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.i_rx_dv) begin
                    en_d         = '1;
                    mask_taken_d = 1'b0;
                    first_done_d = 1'b0;
                    hold_full_d  = 1'b0;
                    if (bus.i_rx_er) begin
                        state_d = ST_DISCARD;
                        part_d  = '0;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_PACK;
                        part_d  = part_ins;
                        cnt_d   = CW'(1);
                    end
                end
            end
            ST_PACK: begin
                // Only the first mask of a frame counts; channels already past sof are dropped
                if (bus.i_dst_valid && !mask_taken_q) begin
                    mask_taken_d = 1'b1;
                    en_d         = en_q & bus.i_dst_mask;
                    drop_d       = en_q & ~bus.i_dst_mask & {NO{first_done_q}};
                end
                if (!bus.i_rx_dv) begin
                    state_d  = ST_IDLE;
                    out_go   = 1'b1;
                    out_last = 1'b1;
                    if (hold_full_q) begin
                        word_d = hold_q;
                    end else begin
                        word_d  = part_q;
                        empty_d = CW'(BPW - 32'(cnt_q));
                    end
                    hold_full_d = 1'b0;
                    part_d      = '0;
                    cnt_d       = '0;
                end else if (bus.i_rx_er) begin
                    state_d     = ST_DISCARD;
                    drop_d      = drop_d | (en_q & {NO{first_done_q}});
                    hold_full_d = 1'b0;
                    part_d      = '0;
                    cnt_d       = '0;
                end else begin
                    if (hold_full_q) begin
                        out_go      = 1'b1;
                        word_d      = hold_q;
                        hold_full_d = 1'b0;
                    end
                    if (cnt_q == CW'(BPW - 1)) begin
                        hold_d      = part_ins;
                        hold_full_d = 1'b1;
                        part_d      = '0;
                        cnt_d       = '0;
                    end else begin
                        part_d = part_ins;
                        cnt_d  = cnt_q + CW'(1);
                    end
                end
            end
            ST_DISCARD: begin
                if (!bus.i_rx_dv) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A mask arriving with a word already governs that word
        if (out_go) begin
            valid_d      = en_d;
            sof_d        = en_d & {NO{!first_done_q}};
            eof_d        = en_d & {NO{out_last}};
            first_done_d = 1'b1;
        end

        busy_d = (state_d != ST_IDLE);
    end

    assign bus.o_word  = {NO{word_q}};
    assign bus.o_empty = {NO{empty_q}};
    assign bus.o_valid = valid_q;
    assign bus.o_sof   = sof_q;
    assign bus.o_eof   = eof_q;
    assign bus.o_drop  = drop_q;
    assign bus.o_busy  = busy_q;
endmodule
